// File: rtl/shift_register_universal.sv
// shift_register_universal
// WIDTH-bit universal register: hold, parallel load, shift left/right,
// rotate left/right, increment and decrement, selected by a 3-bit mode.
// Flags: zero (combinational from q), sout (registered serial-out bit),
// co (registered one-cycle carry/borrow pulse from count operations).
// Optional build macro SHIFTREG_PARITY_EN adds a 'parity' output that is
// the XOR reduction of q.
module shift_register_universal #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             zero,
`ifdef SHIFTREG_PARITY_EN
  output logic             parity,
`endif
  output logic             co
);

  // Shift/rotate indexing needs at least two bits to be meaningful.
  generate
    if (WIDTH < 2) begin : g_width_check
      $error("shift_register_universal: WIDTH must be >= 2");
    end
  endgenerate

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             co_q, co_d;

  // Candidate next values for each bit-moving operation, built per bit so
  // the end bits (serial input / wrap-around) are explicit.
  logic [WIDTH-1:0] shl_v, shr_v, rol_v, ror_v;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign shl_v[gi] = sin;
        assign rol_v[gi] = q_q[WIDTH-1];
      end else begin : g_not_lsb
        assign shl_v[gi] = q_q[gi-1];
        assign rol_v[gi] = q_q[gi-1];
      end
      if (gi == WIDTH-1) begin : g_msb
        assign shr_v[gi] = sin;
        assign ror_v[gi] = q_q[0];
      end else begin : g_not_msb
        assign shr_v[gi] = q_q[gi+1];
        assign ror_v[gi] = q_q[gi+1];
      end
    end
  endgenerate

  // Wrap detection for the count operations: only the all-ones / all-zeros
  // starting values produce a carry / borrow.
  logic q_all_ones;
  logic q_all_zero;
  assign q_all_ones = &q_q;
  assign q_all_zero = ~|q_q;

  // Next-state selection; co defaults low so it can only ever pulse.
  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    co_d   = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          q_d = q_q;
        end
        MODE_LOAD: begin
          q_d = d;
        end
        MODE_SHL: begin
          q_d    = shl_v;
          sout_d = q_q[WIDTH-1];
        end
        MODE_SHR: begin
          q_d    = shr_v;
          sout_d = q_q[0];
        end
        MODE_ROL: begin
          q_d    = rol_v;
          sout_d = q_q[WIDTH-1];
        end
        MODE_ROR: begin
          q_d    = ror_v;
          sout_d = q_q[0];
        end
        MODE_INC: begin
          q_d  = q_q + ONE;
          co_d = q_all_ones;
        end
        MODE_DEC: begin
          q_d  = q_q - ONE;
          co_d = q_all_zero;
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end
  end

  // State register; reset overrides any operation requested in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RESET_VALUE;
      sout_q <= 1'b0;
      co_q   <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      co_q   <= co_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign co   = co_q;
  assign zero = q_all_zero;

`ifdef SHIFTREG_PARITY_EN
  assign parity = ^q_q;
`endif

endmodule
